layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
Top-level run controller for the cube-classification network. It owns the pass order: buffer fill, then CNN and ELU for each of NUM_CONV conv layers plus the affine layer, then the comparator, then finish. It drives the load/select controls of the cube buffer, cnn_layer, elu_layer and comp_layer, and waits on their valid handshakes. It also latches the final class.

Parameters:
BUF_BEATS, 1, number of 120-bit input words accepted in the buffer phase (1..15)
NUM_CONV, 4, number of conv layers before the affine layer (1..7)
TIMEOUT, 1024, maximum wait cycles for any unit valid before a watchdog abort (watchdog build only)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
run  in  1  start request; sampled only in IDLE
abort  in  1  synchronous abort; wins over every other event
d_valid  in  1  input word valid (buffer phase)
d_ready  out  1  high in BUF; word accepted when d_valid&d_ready
buf_load  out  1  = d_valid&d_ready; loads cube buffer
cnn_load  out  1  high throughout CNN state
layer_sel  out  3  0..NUM_CONV-1 = conv layer, NUM_CONV = affine
src_sel  out  1  0 = CNN input from buffer (layer_sel==0), 1 = from elu output
cnn_valid  in  1  cnn_layer done
elu_load  out  1  high throughout ELU state
elu_valid  in  1  elu_layer done
comp_load  out  1  high throughout COMP state
comp_valid  in  1  comp_layer done
comp_q  in  4  class index from comp_layer
busy  out  1  state != IDLE
valid  out  1  one-cycle pulse in FIN
q  out  4  latched class; held until the next accepted run
timeout  out  1  sticky watchdog error; cleared by an accepted run or rst
cs  out  3  current state code (debug)

Behaviour:
- States and codes: IDLE=0, BUF=1, CNN=2, ELU=3, COMP=4, FIN=5. All transitions are registered.
- IDLE: run=1 -> BUF. On this transition, beat_cnt, layer_sel and timeout clear.
- BUF: beat_cnt increments on each accepted word. On the accept that makes the count BUF_BEATS -> CNN with layer_sel=0. d_valid outside BUF is ignored and d_ready=0.
- CNN: cnn_valid -> ELU. layer_sel is unchanged.
- ELU: on elu_valid, if layer_sel<NUM_CONV then layer_sel+1 -> CNN; if layer_sel==NUM_CONV -> COMP.
- COMP: comp_valid -> FIN. comp_q is latched into q on the same edge.
- FIN: valid=1 for one cycle, then -> IDLE unconditionally.
- Each unit valid is honoured only in its own state. Stray valids in other states are ignored.
- Load outputs are decoded combinationally from the state, so loads drop on the cycle after the valid is sampled.
- run while busy: ignored, with no queuing.
- abort (any state): next state IDLE. All load outputs are 0 next cycle. q and timeout are kept.
- Reset values: state IDLE; beat_cnt, layer_sel and q = 0; all outputs 0 except src_sel=0.
- rst mid-run forces IDLE on the next edge and is identical to the reset values above.
- Minimum run with all valids returned combinationally the cycle after load rises: 1 + BUF_BEATS + 2*(NUM_CONV+1)*2 + 2 + 1 cycles, from run to valid.

Optional Feature:
- Macro: LAYER_SEQUENCER_WATCHDOG_EN.
- Defined: a wait counter clears on every state change. It increments each cycle in BUF, CNN, ELU or COMP. On reaching TIMEOUT it sets timeout=1 and forces IDLE with no valid pulse, and q is unchanged.
- Undefined: no counter exists, timeout is tied 0, and the TIMEOUT parameter is unused.

Decomposition:
- Shared package/include `layer_seq_pkg`: state codes, LAYER_W=3, AFFINE index macro.
- Optional sub-module `seq_watchdog` (counter + compare, clear/enable inputs, expire output). Instantiate it only under the macro.
- FSM, beat counter and layer counter live in the top.

Test Plan:
- Nominal run, BUF_BEATS=2, NUM_CONV=4, each valid returned 3 cycles after its load. Required: d_ready for 2 accepts; layer_sel steps 0,1,2,3,4 with src_sel 0,1,1,1,1; comp_q=4'd7 gives q=7 and a single valid pulse; busy low after FIN.
- run pulsed during CNN at layer 2, and cnn_valid/elu_valid pulsed in IDLE and BUF. Required: no state change, and the sequence completes normally.
- abort asserted with run in IDLE, and abort asserted during ELU layer 3. Required: IDLE next cycle, all loads 0, previous q=7 retained, no valid pulse.
- rst asserted in COMP. Required: next edge IDLE, q=0, all outputs 0.
- Watchdog build, TIMEOUT=16, cnn_valid withheld. Required: timeout=1 exactly 16 cycles after entry to CNN, state IDLE, no valid; the next accepted run clears timeout.
- Back-to-back runs, with run held high through FIN. Required: IDLE for one cycle, then BUF, and beat_cnt/layer_sel restart at 0.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer: state codes, layer index width
// and the affine-layer index helper.
package layer_seq_pkg;

  localparam int LAYER_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUF  = 3'd1,
    S_CNN  = 3'd2,
    S_ELU  = 3'd3,
    S_COMP = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // The affine layer sits right after the last conv layer.
  function automatic logic [LAYER_W-1:0] affine_idx(input int num_conv);
    return LAYER_W'(num_conv);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle that would make the count reach TIMEOUT.
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = enable && !clear && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expire) cnt <= '0;
    else if (enable)            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Run controller for the cube-classification network: buffer fill, CNN/ELU per
// layer, comparator, finish. Watchdog abort enabled by LAYER_SEQUENCER_WATCHDOG_EN.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int BUF_BEATS = 1,
  parameter int NUM_CONV  = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               abort,
  input  logic               d_valid,
  output logic               d_ready,
  output logic               buf_load,
  output logic               cnn_load,
  output logic [LAYER_W-1:0] layer_sel,
  output logic               src_sel,
  input  logic               cnn_valid,
  output logic               elu_load,
  input  logic               elu_valid,
  output logic               comp_load,
  input  logic               comp_valid,
  input  logic [3:0]         comp_q,
  output logic               busy,
  output logic               valid,
  output logic [3:0]         q,
  output logic               timeout,
  output logic [2:0]         cs
);

  state_t     state;
  logic [3:0] beat_cnt;
  logic       last_beat;

  assign last_beat = (beat_cnt == 4'(BUF_BEATS - 1));

  // Loads are pure state decodes, so they drop the cycle after the valid is taken.
  assign d_ready   = (state == S_BUF);
  assign buf_load  = d_valid && d_ready;
  assign cnn_load  = (state == S_CNN);
  assign elu_load  = (state == S_ELU);
  assign comp_load = (state == S_COMP);
  assign busy      = (state != S_IDLE);
  assign valid     = (state == S_FIN);
  assign src_sel   = (layer_sel != '0);
  assign cs        = state;

`ifdef LAYER_SEQUENCER_WATCHDOG_EN
  logic leave;
  logic wd_expire;
  logic timeout_r;

  assign leave = abort
              || (state == S_IDLE && run)
              || (state == S_BUF  && buf_load && last_beat)
              || (state == S_CNN  && cnn_valid)
              || (state == S_ELU  && elu_valid)
              || (state == S_COMP && comp_valid)
              || (state == S_FIN);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (leave),
    .enable (state inside {S_BUF, S_CNN, S_ELU, S_COMP}),
    .expire (wd_expire)
  );

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      layer_sel <= '0;
      q         <= '0;
`ifdef LAYER_SEQUENCER_WATCHDOG_EN
      timeout_r <= 1'b0;
`endif
    end else if (abort) begin
      state <= S_IDLE;
`ifdef LAYER_SEQUENCER_WATCHDOG_EN
    end else if (wd_expire) begin
      state     <= S_IDLE;
      timeout_r <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: if (run) begin
          state     <= S_BUF;
          beat_cnt  <= '0;
          layer_sel <= '0;
`ifdef LAYER_SEQUENCER_WATCHDOG_EN
          timeout_r <= 1'b0;
`endif
        end
        S_BUF: if (buf_load) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            state     <= S_CNN;
            layer_sel <= '0;
          end
        end
        S_CNN: if (cnn_valid) state <= S_ELU;
        S_ELU: if (elu_valid) begin
          if (layer_sel == affine_idx(NUM_CONV)) begin
            state <= S_COMP;
          end else begin
            state     <= S_CNN;
            layer_sel <= layer_sel + 1'b1;
          end
        end
        S_COMP: if (comp_valid) begin
          state <= S_FIN;
          q     <= comp_q;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
